// File: rtl/ex_stage.sv
// ex_stage: execute stage fed by a show-ahead ID->EX FIFO.
// Runs single-cycle ALU, sensor and car-command ops, plus 16-cycle iterative MULT/DIV.
// Build option: define EX_DIV_UNIT_EN to build the divider; when it is undefined,
// opcode 10010 is reported as illegal and div_by_zero is tied low.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   fifo_rd_data          FIFO head packet {unused, B, A, opcode, rd}
//   fifo_empty            FIFO holds no packet
//   fifo_rd_en            pop request (combinational; head consumed on the same edge)
//   WB_data/WB_reg_addr   write-back value and destination register
//   WB_reg_write          1-cycle write-back strobe
//   car_cmd/car_cmd_valid car command and its 1-cycle strobe
//   flag_z/flag_n/flag_c  compare flags, held until the next CMP
//   busy                  MUL/DIV iteration in progress
//   illegal_op            1-cycle pulse for an undefined or disabled opcode
//   div_by_zero           1-cycle pulse alongside a DIV write-back with B==0
module ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned PKT_W  = 42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PKT_W-1:0]  fifo_rd_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] WB_data,
  output logic [REG_AW-1:0] WB_reg_addr,
  output logic              WB_reg_write,
  output logic [1:0]        car_cmd,
  output logic              car_cmd_valid,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              busy,
  output logic              illegal_op,
  output logic              div_by_zero
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned OP_LSB = REG_AW;
  localparam int unsigned A_LSB  = OP_LSB + OP_W;
  localparam int unsigned B_LSB  = A_LSB + DATA_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [OP_W-1:0] OP_MOV   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LD    = 5'b00001;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND   = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR    = 5'b00110;
  localparam logic [OP_W-1:0] OP_NOT   = 5'b00111;
  localparam logic [OP_W-1:0] OP_JMP   = 5'b01000;
  localparam logic [OP_W-1:0] OP_NOP   = 5'b01001;
  localparam logic [OP_W-1:0] OP_OBCHK = 5'b01010;
  localparam logic [OP_W-1:0] OP_LEFT  = 5'b01011;
  localparam logic [OP_W-1:0] OP_RIGHT = 5'b01100;
  localparam logic [OP_W-1:0] OP_STOP  = 5'b01101;
  localparam logic [OP_W-1:0] OP_CONT  = 5'b01110;
  localparam logic [OP_W-1:0] OP_VGRD  = 5'b01111;
  localparam logic [OP_W-1:0] OP_CMP   = 5'b10000;
  localparam logic [OP_W-1:0] OP_MULT  = 5'b10001;
`ifdef EX_DIV_UNIT_EN
  localparam logic [OP_W-1:0] OP_DIV   = 5'b10010;
`endif

`ifdef EX_DIV_UNIT_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  op_a;   // MUL: shifting multiplicand; DIV: dividend shifting out quotient
  logic [DATA_W-1:0]  op_b;   // MUL: shifting multiplier;   DIV: divisor
  logic [DATA_W-1:0]  acc;    // MUL: partial product;       DIV: partial remainder

  // Packet fields
  logic [REG_AW-1:0]  pkt_rd;
  logic [OP_W-1:0]    pkt_op;
  logic [DATA_W-1:0]  pkt_a;
  logic [DATA_W-1:0]  pkt_b;
  logic [DATA_W-1:0]  pkt_diff;
  logic [OP_W-1:0]    car_off;
  logic               pkt_unused;

  assign pkt_rd     = fifo_rd_data[OP_LSB-1:0];
  assign pkt_op     = fifo_rd_data[A_LSB-1:OP_LSB];
  assign pkt_a      = fifo_rd_data[B_LSB-1:A_LSB];
  assign pkt_b      = fifo_rd_data[B_LSB+DATA_W-1:B_LSB];
  assign pkt_unused = fifo_rd_data[PKT_W-1];
  assign pkt_diff   = pkt_a - pkt_b;
  assign car_off    = pkt_op - OP_LEFT;

  // Pop only when idle; the iterative units stall the FIFO
  assign fifo_rd_en = (state == IDLE) && !fifo_empty && !reset;

  // Shift-add step: accumulate the multiplicand when the current multiplier LSB is set
  logic [DATA_W-1:0] mul_sum;
  assign mul_sum = acc + (op_b[0] ? op_a : '0);

`ifdef EX_DIV_UNIT_EN
  // Restoring divide step: bring in the next dividend bit, subtract if it fits
  logic [DATA_W:0]   div_trial;
  logic              div_ge;
  logic [DATA_W:0]   div_rem;
  logic [DATA_W-1:0] div_quo;
  assign div_trial = {acc, op_a[DATA_W-1]};
  assign div_ge    = div_trial >= {1'b0, op_b};
  assign div_rem   = div_ge ? (div_trial - {1'b0, op_b}) : div_trial;
  assign div_quo   = {op_a[DATA_W-2:0], div_ge};
`endif

  // FSM, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op_a          <= '0;
      op_b          <= '0;
      acc           <= '0;
      WB_data       <= '0;
      WB_reg_addr   <= '0;
      WB_reg_write  <= 1'b0;
      car_cmd       <= 2'b00;
      car_cmd_valid <= 1'b0;
      flag_z        <= 1'b0;
      flag_n        <= 1'b0;
      flag_c        <= 1'b0;
      busy          <= 1'b0;
      illegal_op    <= 1'b0;
`ifdef EX_DIV_UNIT_EN
      div_by_zero   <= 1'b0;
`endif
    end else begin
      WB_reg_write  <= 1'b0;
      car_cmd_valid <= 1'b0;
      illegal_op    <= 1'b0;
`ifdef EX_DIV_UNIT_EN
      div_by_zero   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fifo_rd_en) begin
            case (pkt_op)
              OP_MOV: begin
                WB_data <= pkt_a; WB_reg_addr <= pkt_rd; WB_reg_write <= 1'b1;
              end
              OP_ADD: begin
                WB_data <= pkt_a + pkt_b; WB_reg_addr <= pkt_rd; WB_reg_write <= 1'b1;
              end
              OP_SUB: begin
                WB_data <= pkt_diff; WB_reg_addr <= pkt_rd; WB_reg_write <= 1'b1;
              end
              OP_AND: begin
                WB_data <= pkt_a & pkt_b; WB_reg_addr <= pkt_rd; WB_reg_write <= 1'b1;
              end
              OP_OR: begin
                WB_data <= pkt_a | pkt_b; WB_reg_addr <= pkt_rd; WB_reg_write <= 1'b1;
              end
              OP_NOT: begin
                WB_data <= ~pkt_a; WB_reg_addr <= pkt_rd; WB_reg_write <= 1'b1;
              end
              OP_OBCHK: begin
                WB_data <= DATA_W'(pkt_a < pkt_b); WB_reg_addr <= pkt_rd; WB_reg_write <= 1'b1;
              end
              OP_VGRD: begin
                WB_data <= (pkt_a < pkt_b) ? pkt_a : pkt_b; WB_reg_addr <= pkt_rd;
                WB_reg_write <= 1'b1;
              end
              OP_LD, OP_JMP, OP_NOP: begin
              end
              OP_CMP: begin
                flag_z <= (pkt_a == pkt_b);
                flag_n <= pkt_diff[DATA_W-1];
                flag_c <= (pkt_a < pkt_b);
              end
              OP_LEFT, OP_RIGHT, OP_STOP, OP_CONT: begin
                car_cmd       <= car_off[1:0];
                car_cmd_valid <= 1'b1;
              end
              OP_MULT: begin
                state       <= MUL;
                busy        <= 1'b1;
                cnt         <= '0;
                acc         <= '0;
                op_a        <= pkt_a;
                op_b        <= pkt_b;
                WB_reg_addr <= pkt_rd;
              end
`ifdef EX_DIV_UNIT_EN
              OP_DIV: begin
                state       <= DIV;
                busy        <= 1'b1;
                cnt         <= '0;
                acc         <= '0;
                op_a        <= pkt_a;
                op_b        <= pkt_b;
                WB_reg_addr <= pkt_rd;
              end
`endif
              default: illegal_op <= 1'b1;
            endcase
          end
        end
        MUL: begin
          cnt  <= cnt + CNT_W'(1);
          acc  <= mul_sum;
          op_a <= {op_a[DATA_W-2:0], 1'b0};
          op_b <= {1'b0, op_b[DATA_W-1:1]};
          if (cnt == CNT_LAST) begin
            WB_data      <= mul_sum;
            WB_reg_write <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
`ifdef EX_DIV_UNIT_EN
        DIV: begin
          cnt  <= cnt + CNT_W'(1);
          acc  <= div_rem[DATA_W-1:0];
          op_a <= div_quo;
          if (cnt == CNT_LAST) begin
            WB_data      <= div_quo;
            WB_reg_write <= 1'b1;
            div_by_zero  <= (op_b == '0);
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef EX_DIV_UNIT_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage with a small show-ahead FIFO model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [41:0] fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] WB_data;
  logic [3:0]  WB_reg_addr;
  logic        WB_reg_write;
  logic [1:0]  car_cmd;
  logic        car_cmd_valid;
  logic        flag_z, flag_n, flag_c;
  logic        busy;
  logic        illegal_op;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [41:0] q[$];

  ex_stage dut (
    .clk(clk), .reset(reset),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .WB_data(WB_data), .WB_reg_addr(WB_reg_addr), .WB_reg_write(WB_reg_write),
    .car_cmd(car_cmd), .car_cmd_valid(car_cmd_valid),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .busy(busy), .illegal_op(illegal_op), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // FIFO model: pop on the active edge, present the new head before the next edge
  always @(posedge clk) begin
    if (fifo_rd_en && q.size() > 0) void'(q.pop_front());
  end

  always @(negedge clk) begin
    fifo_empty   = (q.size() == 0);
    fifo_rd_data = (q.size() > 0) ? q[0] : 42'd0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit 41 set on every packet so a design that reads it would misbehave
  task automatic push(input logic [4:0] op, input logic [3:0] rd,
                      input logic [15:0] a, input logic [15:0] b);
    q.push_back({1'b1, b, a, op, rd});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic [15:0] data, input logic [3:0] addr);
    check({tag, "_we"}, WB_reg_write, 1'b1);
    check({tag, "_data"}, WB_data, data);
    check({tag, "_addr"}, WB_reg_addr, addr);
  endtask

  // Launch an iterative op (already queued) and check the busy window and write-back
  task automatic run_iter(input string tag, input logic [15:0] data, input logic [3:0] addr);
    int good;
    good = 0;
    step();
    for (int i = 0; i < 16; i++) begin
      if (busy && !fifo_rd_en && !WB_reg_write) good++;
      step();
    end
    check({tag, "_busy16"}, good, 16);
    check_wb(tag, data, addr);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;

    // 1. reset with a non-empty FIFO; 2. back-to-back ADD/SUB
    push(5'b00011, 4'd5, 16'hFFFF, 16'd2);
    push(5'b00100, 4'd6, 16'd3, 16'd5);
    step();
    step();
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_we", WB_reg_write, 1'b0);
    check("rst_data", WB_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {flag_z, flag_n, flag_c}, 3'b000);
    check("rst_strobes", {car_cmd_valid, car_cmd, illegal_op, div_by_zero}, 5'b0);
    reset = 1'b0;
    #1;
    check("idle_rd_en", fifo_rd_en, 1'b1);
    step();
    check_wb("add", 16'h0001, 4'd5);
    step();
    check_wb("sub", 16'hFFFE, 4'd6);
    step();
    check("sub_after_we", WB_reg_write, 1'b0);

    // 3. MULT 300*300 with a queued ADD
    push(5'b10001, 4'd2, 16'd300, 16'd300);
    push(5'b00011, 4'd3, 16'd1, 16'd1);
    run_iter("mult", 16'h5F90, 4'd2);
    step();
    check_wb("add_after_mult", 16'h0002, 4'd3);
    step();

    // 4. DIV
`ifdef EX_DIV_UNIT_EN
    push(5'b10010, 4'd4, 16'd100, 16'd7);
    run_iter("div", 16'd14, 4'd4);
    check("div_dz", div_by_zero, 1'b0);
    step();
    push(5'b10010, 4'd8, 16'd9, 16'd0);
    run_iter("div0", 16'hFFFF, 4'd8);
    check("div0_dz", div_by_zero, 1'b1);
    step();
    check("div0_dz_pulse", div_by_zero, 1'b0);
`else
    push(5'b10010, 4'd4, 16'd100, 16'd7);
    step();
    check("div_off_illegal", illegal_op, 1'b1);
    check("div_off_we", WB_reg_write, 1'b0);
    check("div_off_busy", busy, 1'b0);
    step();
    check("div_off_pulse", illegal_op, 1'b0);
    check("div_off_dz", div_by_zero, 1'b0);
`endif

    // Undefined opcode
    push(5'b11111, 4'd1, 16'd1, 16'd1);
    step();
    check("illegal", illegal_op, 1'b1);
    check("illegal_we", WB_reg_write, 1'b0);
    step();

    // 5. CMP, OB_CHECK, VELOCITY_GUARD, STOP back-to-back; rd=0 is a real register
    push(5'b10000, 4'd9, 16'd3, 16'd5);
    push(5'b01010, 4'd0, 16'd10, 16'd20);
    push(5'b01111, 4'd11, 16'd90, 16'd60);
    push(5'b01101, 4'd12, 16'd0, 16'd0);
    push(5'b01001, 4'd13, 16'd7, 16'd7);
    step();
    check("cmp_flags", {flag_z, flag_n, flag_c}, 3'b011);
    check("cmp_we", WB_reg_write, 1'b0);
    step();
    check_wb("obchk", 16'd1, 4'd0);
    step();
    check_wb("vguard", 16'd60, 4'd11);
    step();
    check("stop_cmd", car_cmd, 2'b10);
    check("stop_valid", car_cmd_valid, 1'b1);
    check("stop_we", WB_reg_write, 1'b0);
    step();
    check("nop_strobes", {WB_reg_write, car_cmd_valid, illegal_op}, 3'b000);
    check("flags_held", {flag_z, flag_n, flag_c}, 3'b011);
    step();

    // 6. Reset in the middle of a MULT
    push(5'b10001, 4'd2, 16'd300, 16'd300);
    push(5'b00011, 4'd7, 16'd5, 16'd6);
    step();
    for (int i = 0; i < 7; i++) step();
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    check("abort_busy", busy, 1'b0);
    check("abort_we", WB_reg_write, 1'b0);
    check("abort_rd_en", fifo_rd_en, 1'b0);
    reset = 1'b0;
    step();
    check_wb("add_after_abort", 16'd11, 4'd7);
    step();
    check("final_we", WB_reg_write, 1'b0);
    check("final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
